// File: rtl/led_pkg.sv
// led_pkg: mode encoding, speed constants and mode sequencing
// shared by the LED pattern controller and its button front end.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_CHASE = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_COUNT = 2'd3
   } mode_e;

   localparam logic SPEED_SLOW = 1'b0;
   localparam logic SPEED_FAST = 1'b1;

   localparam int unsigned FAST_DIV = 4;

   function automatic mode_e mode_next(input mode_e m);
      mode_e n;
      n = MODE_OFF;
      unique case (m)
         MODE_OFF:   n = MODE_CHASE;
         MODE_CHASE: n = MODE_BLINK;
         MODE_BLINK: n = MODE_COUNT;
         default:    n = MODE_OFF;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/led_pattern_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stable-level debounce counter
// and single-cycle press pulse for one active-low push-button.
module btn_debounce
   import led_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic press
);

   localparam int unsigned CW =
      (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync;
   logic          deb_n;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= 2'b11;
         deb_n <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], btn_n};
         press <= 1'b0;
         if (sync[1] == deb_n) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            // only the falling edge of the level is an event
            deb_n <= sync[1];
            cnt   <= '0;
            press <= ~sync[1];
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: button-driven mode/speed FSM animating active-low LEDs.
// Define LED_PWM_DIM_EN to dim lit LEDs to a 25% duty cycle.
module led_pattern_ctrl
   import led_pkg::*;
#(
   parameter int unsigned N_LED      = 4,
   parameter int unsigned TICK_DIV   = 12500000,
   parameter int unsigned DEB_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s1_n,
   input  logic             s2_n,
   output logic [N_LED-1:0] led_n,
   output logic [1:0]       mode_o,
   output logic             speed_o
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] SLOW_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] FAST_LAST = PW'(TICK_DIV / FAST_DIV - 1);

   logic             ev1;
   logic             ev2;
   mode_e            mode;
   logic             speed;
   logic [PW-1:0]    pre;
   logic [PW-1:0]    pre_last;
   logic             wrap;
   logic             tick;
   logic [N_LED-1:0] pat;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb1 (
      .clk   (clk),
      .rst   (rst),
      .btn_n (s1_n),
      .press (ev1)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb2 (
      .clk   (clk),
      .rst   (rst),
      .btn_n (s2_n),
      .press (ev2)
   );

   function automatic logic [N_LED-1:0] pat_init(input mode_e m);
      logic [N_LED-1:0] p;
      p = '0;
      unique case (m)
         MODE_CHASE: p = N_LED'(1);
         MODE_BLINK: p = '1;
         default:    p = '0;
      endcase
      return p;
   endfunction

   function automatic logic [N_LED-1:0] pat_step(
      input mode_e            m,
      input logic [N_LED-1:0] p
   );
      logic [N_LED-1:0] n;
      n = '0;
      unique case (m)
         MODE_CHASE: n = {p[N_LED-2:0], p[N_LED-1]};
         MODE_BLINK: n = ~p;
         MODE_COUNT: n = p + N_LED'(1);
         default:    n = '0;
      endcase
      return n;
   endfunction

   assign pre_last = (speed == SPEED_FAST) ? FAST_LAST : SLOW_LAST;
   assign wrap     = (pre == pre_last);
   // a press restarts the step period, so its coincident tick is lost
   assign tick     = wrap & ~ev1 & ~ev2;

   always_ff @(posedge clk) begin
      if (rst) begin
         mode  <= MODE_OFF;
         speed <= SPEED_SLOW;
         pre   <= '0;
         pat   <= '0;
      end else begin
         if (ev1 || ev2 || wrap) begin
            pre <= '0;
         end else begin
            pre <= pre + PW'(1);
         end
         if (ev1) begin
            mode <= mode_next(mode);
            pat  <= pat_init(mode_next(mode));
         end else if (tick) begin
            pat <= pat_step(mode, pat);
         end
         if (ev2) begin
            speed <= ~speed;
         end
      end
   end

   assign mode_o  = mode;
   assign speed_o = speed;

`ifdef LED_PWM_DIM_EN
   logic [1:0] pwm;

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm   <= 2'd0;
         led_n <= '1;
      end else begin
         pwm   <= pwm + 2'd1;
         led_n <= (pwm == 2'd0) ? ~pat : '1;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         led_n <= '1;
      end else begin
         led_n <= ~pat;
      end
   end
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed checks of debounce latency, mode
// sequencing, pattern stepping, speed toggle and simultaneous presses.
module tb_led_pattern_ctrl;
   import led_pkg::*;

   logic       clk;
   logic       rst;
   logic       s1_n;
   logic       s2_n;
   logic [3:0] led_n;
   logic [1:0] mode_o;
   logic       speed_o;

   int checks;
   int errors;
   int cyc;

   led_pattern_ctrl #(
      .N_LED      (4),
      .TICK_DIV   (8),
      .DEB_CYCLES (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s1_n    (s1_n),
      .s2_n    (s2_n),
      .led_n   (led_n),
      .mode_o  (mode_o),
      .speed_o (speed_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   // led value registered at sample index cyc, given active-high pattern p
   function automatic logic [3:0] exp_led(input logic [3:0] p);
`ifdef LED_PWM_DIM_EN
      return (((cyc - 1) % 4) == 0) ? ~p : 4'hF;
`else
      return ~p;
`endif
   endfunction

   task automatic test_reset;
      rst  = 1'b1;
      s1_n = 1'b1;
      s2_n = 1'b1;
      step(2);
      for (int i = 0; i < 3; i++) begin
         s1_n = i[0];
         s2_n = ~i[0];
         step(1);
         checks++;
         if (led_n !== 4'hF || mode_o !== 2'd0 || speed_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got led=%b mode=%0d spd=%b want 1111 0 0",
                     led_n, mode_o, speed_o);
         end
      end
      s1_n = 1'b1;
      s2_n = 1'b1;
      cyc  = 0;
      rst  = 1'b0;
      step(4);
      checks++;
      if (led_n !== 4'hF || mode_o !== 2'd0 || speed_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle got led=%b mode=%0d spd=%b want 1111 0 0",
                  led_n, mode_o, speed_o);
      end
   endtask

   task automatic test_chase;
      logic [3:0] pat;
      s1_n = 1'b0;
      step(6);
      checks++;
      if (mode_o !== 2'd0) begin
         errors++;
         $display("FAIL chase_early got mode=%0d want 0", mode_o);
      end
      step(1);
      checks++;
      if (mode_o !== 2'd1) begin
         errors++;
         $display("FAIL chase_lat7 got mode=%0d want 1", mode_o);
      end
      pat = 4'b0001;
      step(1);
      checks++;
      if (led_n !== exp_led(pat)) begin
         errors++;
         $display("FAIL chase_init got %b want %b", led_n, exp_led(pat));
      end
      for (int i = 0; i < 4; i++) begin
         pat = {pat[2:0], pat[3]};
         step(8);
         checks++;
         if (led_n !== exp_led(pat) || mode_o !== 2'd1) begin
            errors++;
            $display("FAIL chase_step%0d got led=%b mode=%0d want %b 1",
                     i, led_n, mode_o, exp_led(pat));
         end
      end
      s1_n = 1'b1;
      step(10);
      checks++;
      if (mode_o !== 2'd1) begin
         errors++;
         $display("FAIL release_noevent got mode=%0d want 1", mode_o);
      end
   endtask

   task automatic test_bounce;
      for (int i = 0; i < 5; i++) begin
         s1_n = 1'b0;
         step(2);
         s1_n = 1'b1;
         step(2);
      end
      step(8);
      checks++;
      if (mode_o !== 2'd1) begin
         errors++;
         $display("FAIL bounce got mode=%0d want 1", mode_o);
      end
   endtask

   task automatic test_blink_count;
      logic [3:0] cnt;
      s1_n = 1'b0;
      step(7);
      checks++;
      if (mode_o !== 2'd2) begin
         errors++;
         $display("FAIL blink_mode got mode=%0d want 2", mode_o);
      end
      step(1);
      checks++;
      if (led_n !== exp_led(4'hF)) begin
         errors++;
         $display("FAIL blink_init got %b want %b", led_n, exp_led(4'hF));
      end
      s1_n = 1'b1;
      step(10);
      s1_n = 1'b0;
      step(7);
      checks++;
      if (mode_o !== 2'd3) begin
         errors++;
         $display("FAIL count_mode got mode=%0d want 3", mode_o);
      end
      cnt = 4'd0;
      step(1);
      checks++;
      if (led_n !== exp_led(cnt)) begin
         errors++;
         $display("FAIL count_init got %b want %b", led_n, exp_led(cnt));
      end
      for (int i = 1; i <= 16; i++) begin
         cnt = cnt + 4'd1;
         step(8);
         checks++;
         if (led_n !== exp_led(cnt)) begin
            errors++;
            $display("FAIL count_step%0d got %b want %b",
                     i, led_n, exp_led(cnt));
         end
      end
      s1_n = 1'b1;
      step(10);
   endtask

   task automatic test_speed;
      logic [3:0] pat;
      s1_n = 1'b0;
      step(7);
      checks++;
      if (mode_o !== 2'd0) begin
         errors++;
         $display("FAIL wrap_off got mode=%0d want 0", mode_o);
      end
      s1_n = 1'b1;
      step(10);
      s1_n = 1'b0;
      step(7);
      checks++;
      if (mode_o !== 2'd1) begin
         errors++;
         $display("FAIL speed_chase got mode=%0d want 1", mode_o);
      end
      s2_n = 1'b0;
      step(7);
      checks++;
      if (speed_o !== 1'b1 || mode_o !== 2'd1) begin
         errors++;
         $display("FAIL speed_fast got spd=%b mode=%0d want 1 1",
                  speed_o, mode_o);
      end
      pat = 4'b0001;
      step(1);
      checks++;
      if (led_n !== exp_led(pat)) begin
         errors++;
         $display("FAIL fast_hold got %b want %b", led_n, exp_led(pat));
      end
      for (int i = 0; i < 3; i++) begin
         pat = {pat[2:0], pat[3]};
         step(2);
         checks++;
         if (led_n !== exp_led(pat)) begin
            errors++;
            $display("FAIL fast_step%0d got %b want %b",
                     i, led_n, exp_led(pat));
         end
      end
      s1_n = 1'b1;
      s2_n = 1'b1;
      step(10);
   endtask

   task automatic test_both;
      int lit;
      s1_n = 1'b0;
      s2_n = 1'b0;
      step(7);
      checks++;
      if (mode_o !== 2'd2 || speed_o !== 1'b0) begin
         errors++;
         $display("FAIL both_evt got mode=%0d spd=%b want 2 0",
                  mode_o, speed_o);
      end
      lit = 0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         if (led_n === 4'h0) lit++;
         checks++;
         if (led_n !== exp_led(4'hF)) begin
            errors++;
            $display("FAIL both_led%0d got %b want %b",
                     i, led_n, exp_led(4'hF));
         end
      end
`ifdef LED_PWM_DIM_EN
      checks++;
      if (lit !== 2) begin
         errors++;
         $display("FAIL pwm_duty got %0d lit want 2", lit);
      end
`else
      checks++;
      if (lit !== 8) begin
         errors++;
         $display("FAIL steady_lit got %0d lit want 8", lit);
      end
`endif
      s1_n = 1'b1;
      s2_n = 1'b1;
      step(10);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      rst    = 1'b1;
      s1_n   = 1'b1;
      s2_n   = 1'b1;
      test_reset();
      test_chase();
      test_bounce();
      test_blink_count();
      test_speed();
      test_both();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Upstream driver for the four on-board active-low LEDs (PIN_87 group) on the Cyclone IV board.
- Takes the two raw push-buttons s1/s2 (PIN_88/89, active-low), synchronises and debounces them.
- s1 cycles a display mode; s2 toggles pattern speed.
- Produces a registered active-low LED vector, so LEDs show animated patterns instead of tied-off constants.

Parameters:
- N_LED, 4, number of LEDs driven (min 2).
- TICK_DIV, 12500000, clock cycles per pattern step in slow speed (must be a multiple of 4; 4 Hz at 50 MHz).
- DEB_CYCLES, 1000000, consecutive stable synchronised samples required to accept a button level change (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- s1_n  in  1  raw button 1, active-low, asynchronous to clk.
- s2_n  in  1  raw button 2, active-low, asynchronous to clk.
- led_n  out  N_LED  LED drive, active-low (0 = lit), registered.
- mode_o  out  2  current mode: 0 OFF, 1 CHASE, 2 BLINK, 3 COUNT.
- speed_o  out  1  0 = slow, 1 = fast.

Behaviour:
- Interface is one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values:
  - mode_o = 0, speed_o = 0, led_n = all 1 (all LEDs off).
  - Debounced levels = released; all counters = 0; internal pattern pat = 0.
- Input path, per button:
  - 2-FF synchroniser.
  - Debounce counter compares the synchronised sample with the debounced level. It increments while they differ and clears when they match.
  - When the count reaches DEB_CYCLES-1 with the samples still differing, the debounced level flips and the counter clears.
  - Press event = one-cycle pulse on a released->pressed transition of the debounced level. Release generates no event.
- Latency:
  - Raw input held at its new value: debounced level flips 2+DEB_CYCLES cycles later.
  - mode_o / speed_o update on the next edge.
- s1 event: mode advances OFF->CHASE->BLINK->COUNT->OFF. pat loads the new mode's init value; prescaler clears.
- s2 event: speed_o toggles; prescaler clears; pat is unchanged.
- Both events in the same cycle: both are applied.
- Prescaler:
  - Counts 0..P-1, where P = TICK_DIV (slow) or TICK_DIV/4 (fast).
  - Emits a tick on the cycle it wraps to 0.
  - A tick that coincides with any press event is dropped.
- Pattern per tick, with pat as active-high internal state:
  - OFF: pat = 0, ticks ignored.
  - CHASE: init 0...01; rotate left by 1; MSB wraps to bit 0.
  - BLINK: init all 1; pat = ~pat.
  - COUNT: init 0; pat = pat+1 mod 2^N_LED (all-ones wraps to 0).
- led_n is registered = ~pat, one cycle after pat updates.
- A button held continuously produces exactly one event. Bounce shorter than DEB_CYCLES produces none.
- Reset asserted mid-debounce or mid-pattern returns everything to reset values on that edge. A button held through reset release produces an event once it is debounced.

Optional Feature:
- Macro: LED_PWM_DIM_EN.
- With the macro defined:
  - Adds a 2-bit free-running pwm counter, reset to 0.
  - Lit LEDs are driven low only on cycles where pwm == 0 (25% duty). Unlit LEDs stay high.
  - The pattern/mode logic is unchanged.
- Without the macro: led_n = ~pat steady; no pwm counter is synthesised.

Decomposition:
- Shared package led_pkg:
  - Mode enum (MODE_OFF/CHASE/BLINK/COUNT, 2 bits).
  - Mode-next function.
  - Constants SPEED_SLOW/SPEED_FAST.
  - Fast-divisor constant 4.
- Sub-module btn_debounce (synchroniser + debounce counter + press pulse, parameter DEB_CYCLES). Instantiated twice.
- Top holds the mode FSM, prescaler and pattern register.

Test Plan (TICK_DIV=8, DEB_CYCLES=4):
- Reset -> led_n=1111, mode_o=0, speed_o=0. Hold rst for 3 cycles with buttons toggling -> outputs stay at reset values.
- s1_n low and held -> mode_o=1 exactly 7 cycles after the input edge; led_n=1110; after each further 8 cycles: 1101, 1011, 0111, 1110.
- s1_n pulses low for 2 cycles, 5 times, with 2-cycle gaps (bounce) -> no event, mode_o unchanged.
- Three clean s1 presses -> BLINK then COUNT. In COUNT, 16 ticks -> led_n steps 1111, 1110, ..., 0000, then wraps to 1111.
- In CHASE, press s2 -> speed_o=1; steps every 2 cycles. Press s1 and s2 in the same debounced cycle -> mode=BLINK, speed_o=0, led_n=0000 one cycle later.
- With LED_PWM_DIM_EN in BLINK with pat all-1 -> led_n=0000 on 1 of every 4 cycles and 1111 otherwise.
